if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch stage for the single-issue Simple-RISC-V core. It holds the PC, issues one request per instruction on a valid/grant/response instruction-memory port that tolerates wait states, and delivers the fetched word with a one-cycle `IF_kick_up` pulse. On `WB_kick_up` it computes the next PC: sequential, conditional branch, JAL or JALR. A misaligned target raises a sticky fault.

## Interface
- `XLEN`, 32: PC/address/operand width; must be ≥ 8.
- `RESET_VECTOR`, 0: PC value after reset; must be 4-byte aligned.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `WB_kick_up`  in  1  commit pulse for the current instruction; the next PC is taken.
- `redirect_type`  in  2  00 sequential, 01 branch, 10 JAL, 11 JALR; sampled with `WB_kick_up`.
- `branch_taken`  in  1  branch condition (branch && ALU zero); used only when type = 01.
- `imme`  in  XLEN  sign-extended byte offset.
- `rs1_val`  in  XLEN  JALR base.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  request address (= PC).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `IF_kick_up`  out  1  one-cycle pulse: `inst`/`inst_pc` are newly valid.
- `inst`  out  32  fetched instruction, held until the next fetch completes.
- `inst_pc`  out  XLEN  PC of `inst`.
- `pc_plus4`  out  XLEN  `inst_pc + 4`, the link value for JAL/JALR.
- `misalign_fault`  out  1  sticky; target bits [1:0] ≠ 0.

## Operation
- States: FETCH, WAIT, HOLD, FAULT. Reset → FETCH, pc = `RESET_VECTOR`.
- FETCH: `imem_req`=1, `imem_addr`=pc. Address stays stable until `imem_gnt`. On gnt → WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: register `inst`←`imem_rdata` and `inst_pc`←pc, set `IF_kick_up` for the next cycle, → HOLD. `imem_rvalid` in any other state is ignored.
- HOLD: waits for `WB_kick_up`. Target selection:
  - seq: pc+4
  - branch: taken ? pc+imme : pc+4
  - JAL: pc+imme
  - JALR: (rs1_val+imme) with bit 0 cleared
- All sums wrap modulo 2^XLEN.
- If target[1:0] ≠ 0: pc is unchanged, `misalign_fault`←1, → FAULT. Otherwise pc←target, → FETCH.
- FAULT: no requests. `IF_kick_up` stays 0. Exits only on reset.
- `WB_kick_up` outside HOLD is ignored; pc and state are unchanged.
- The memory is reset by the same `reset`, so no response outstanding at reset is delivered afterward.

## Timing
- Reset values: `imem_req`=1 (FETCH, combinational from state), `imem_addr`=`RESET_VECTOR`, `IF_kick_up`=0, `inst`=0x00000013 (NOP), `inst_pc`=`RESET_VECTOR`, `pc_plus4`=`RESET_VECTOR`+4, `misalign_fault`=0.
- `imem_req` and `imem_addr` are combinational from registered state and pc. Other outputs are registered.
- Latency with zero wait states (gnt in the request cycle, rvalid one cycle later): request at cycle 0, rvalid at cycle 1, `IF_kick_up` high at cycle 2. Each wait cycle on gnt or rvalid adds one cycle.
- `WB_kick_up` at cycle N in HOLD: new pc and `imem_req` from cycle N+1.
- Commit-to-commit minimum is 3 cycles (N+1 request, N+2 rvalid, N+3 `IF_kick_up`).
- A response in the same cycle as gnt is not accepted; minimum memory latency is 1.
- `IF_kick_up` is exactly one cycle wide per fetched instruction.
- Reset asserted mid-WAIT or mid-HOLD: immediate return to reset values; the pending instruction is discarded.

## Test plan
- Reset release, gnt immediate, rvalid next cycle with 0x00500093 → `IF_kick_up` at cycle 2, `inst`=0x00500093, `inst_pc`=0.
- Three sequential commits, memory with 2 wait cycles on gnt and 1 on rvalid → `imem_addr` 0x4, 0x8, 0xC, stable while gnt is low; each `IF_kick_up` is 1 cycle.
- Branch with pc=0x10, imme=0xFFFFFFF0: taken → next `imem_addr`=0x0; not taken → 0x14. JAL with imme=0x100 → 0x110, `pc_plus4` of the JAL = 0x14.
- JALR with rs1=0x203, imme=0x1: bit 0 is cleared, target 0x204 → fetch at 0x204. With rs1=0x201, imme=0 → target 0x200.
- JALR to 0x102 → `misalign_fault`=1, no further `imem_req`, pc stays. Later `WB_kick_up` and `imem_rvalid` have no effect. Reset clears the fault.
- Reset asserted during WAIT, then rvalid in the next cycle → `IF_kick_up` stays 0 and `imem_addr`=`RESET_VECTOR`. PC wrap: pc=0xFFFFFFFC with seq → 0x0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port bundle for the fetch stage.
// Ports:
//   imem_req    fetch request            (master -> slave)
//   imem_addr   request address          (master -> slave)
//   imem_gnt    request accepted         (slave  -> master)
//   imem_rvalid response data valid      (slave  -> master)
//   imem_rdata  response instruction     (slave  -> master)
interface if_fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one request per instruction
// on a valid/grant/response memory port that tolerates wait states, and
// delivers each fetched word with a one-cycle IF_kick_up pulse. On a commit
// pulse it selects the next PC (sequential, branch, JAL, JALR); a misaligned
// target parks the unit in a sticky fault state until reset.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   WB_kick_up      commit pulse; next PC is taken while holding
//   redirect_type   00 seq, 01 branch, 10 JAL, 11 JALR
//   branch_taken    branch condition, used only for redirect_type 01
//   imme            sign-extended byte offset
//   rs1_val         JALR base
//   imem            instruction-memory port (master side)
//   IF_kick_up      one-cycle pulse: inst/inst_pc newly valid
//   inst, inst_pc   fetched instruction and its PC
//   pc_plus4        inst_pc + 4 (link value)
//   misalign_fault  sticky misaligned-target flag
module if_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WB_kick_up,
  input  logic [1:0]            redirect_type,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       imme,
  input  logic [XLEN-1:0]       rs1_val,
  if_fetch_unit_if.master       imem,
  output logic                  IF_kick_up,
  output logic [31:0]           inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic [XLEN-1:0]       pc_plus4,
  output logic                  misalign_fault
);

  localparam logic [XLEN-1:0] FOUR     = XLEN'(32'd4);
  localparam logic [31:0]     NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] seq_s;
  logic [XLEN-1:0] rel_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;

  // Request and address come straight from registered state so the address
  // is stable for as long as the grant is withheld.
  assign imem.imem_req  = (state_r == ST_FETCH);
  assign imem.imem_addr = pc_r;

  assign seq_s      = pc_r + FOUR;
  assign rel_s      = pc_r + imme;
  assign jalr_sum_s = rs1_val + imme;

  // Next-PC selection; all sums wrap naturally at XLEN bits.
  always_comb begin
    target_s = seq_s;
    case (redirect_type)
      2'b00: target_s = seq_s;
      2'b01: begin
        if (branch_taken) begin
          target_s = rel_s;
        end else begin
          target_s = seq_s;
        end
      end
      2'b10: target_s = rel_s;
      2'b11: target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
      default: target_s = seq_s;
    endcase
  end

  // Fetch FSM with registered outputs; responses outside WAIT and commits
  // outside HOLD fall through without effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_FETCH;
      pc_r           <= RESET_VECTOR;
      IF_kick_up     <= 1'b0;
      inst           <= NOP_INST;
      inst_pc        <= RESET_VECTOR;
      pc_plus4       <= RESET_VECTOR + FOUR;
      misalign_fault <= 1'b0;
    end else begin
      IF_kick_up <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (imem.imem_gnt) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            inst       <= imem.imem_rdata;
            inst_pc    <= pc_r;
            pc_plus4   <= seq_s;
            IF_kick_up <= 1'b1;
            state_r    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (WB_kick_up) begin
            if (target_s[1:0] != 2'b00) begin
              misalign_fault <= 1'b1;
              state_r        <= ST_FAULT;
            end else begin
              pc_r    <= target_s;
              state_r <= ST_FETCH;
            end
          end
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
        default: begin
          state_r <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WB_kick_up = 1'b0;
  logic [1:0]  redirect_type = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] imme = 32'h0;
  logic [31:0] rs1_val = 32'h0;
  logic        IF_kick_up;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        misalign_fault;
  int          checks = 0;
  int          failures = 0;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .WB_kick_up(WB_kick_up),
    .redirect_type(redirect_type), .branch_taken(branch_taken),
    .imme(imme), .rs1_val(rs1_val), .imem(bus),
    .IF_kick_up(IF_kick_up), .inst(inst), .inst_pc(inst_pc),
    .pc_plus4(pc_plus4), .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  // Stimulus only: plays the memory for one fetch starting in FETCH.
  // Returns at the negedge where IF_kick_up should be high; 'stable' reports
  // whether address/request held while the grant was withheld.
  task automatic serve_fetch(input int gw, input int rw, input logic [31:0] data,
                             output logic stable);
    logic [31:0] a0;
    a0 = bus.imem_addr;
    stable = 1'b1;
    for (int i = 0; i < gw; i++) begin
      bus.imem_gnt = 1'b0;
      @(negedge clk);
      if (bus.imem_addr !== a0 || bus.imem_req !== 1'b1) stable = 1'b0;
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (rw) @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic commit(input logic [1:0] t, input logic tk, input logic [31:0] im,
                        input logic [31:0] r1);
    WB_kick_up = 1'b1; redirect_type = t; branch_taken = tk; imme = im; rs1_val = r1;
    @(negedge clk);
    WB_kick_up = 1'b0; redirect_type = 2'b00; branch_taken = 1'b0; imme = 32'h0; rs1_val = 32'h0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rst_req got %b exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
    checks++; if (IF_kick_up !== 1'b0) begin failures++; $display("FAIL rst_kick got %b exp 0", IF_kick_up); end
    checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got %h exp 00000013", inst); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL rst_pc_plus4 got %h exp 4", pc_plus4); end
    checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got %b exp 0", misalign_fault); end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch;
    bus.imem_gnt = 1'b1;                       // cycle 0
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;   // cycle 1
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL ff_req_wait got %b exp 0", bus.imem_req); end
    checks++; if (IF_kick_up !== 1'b0) begin failures++; $display("FAIL ff_kick_early got %b exp 0", IF_kick_up); end
    @(negedge clk);                            // cycle 2
    bus.imem_rvalid = 1'b0;
    checks++; if (IF_kick_up !== 1'b1) begin failures++; $display("FAIL ff_kick got %b exp 1", IF_kick_up); end
    checks++; if (inst !== 32'h0050_0093) begin failures++; $display("FAIL ff_inst got %h exp 00500093", inst); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL ff_inst_pc got %h exp 0", inst_pc); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL ff_pc_plus4 got %h exp 4", pc_plus4); end
    @(negedge clk);
    checks++; if (IF_kick_up !== 1'b0) begin failures++; $display("FAIL ff_kick_width got %b exp 0", IF_kick_up); end
  endtask

  task automatic test_sequential;
    logic        st;
    logic [31:0] ea;
    for (int i = 0; i < 3; i++) begin
      ea = 32'(4 * (i + 1));
      commit(2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (bus.imem_addr !== ea || bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_addr got %h/%b exp %h/1", bus.imem_addr, bus.imem_req, ea); end
      serve_fetch(2, 1, 32'h1000_0000 + ea, st);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL seq_addr_stable got %b exp 1", st); end
      checks++; if (IF_kick_up !== 1'b1 || inst !== 32'h1000_0000 + ea || inst_pc !== ea) begin
        failures++; $display("FAIL seq_deliver got %b/%h/%h exp 1/%h/%h", IF_kick_up, inst, inst_pc, 32'h1000_0000 + ea, ea); end
      @(negedge clk);
      checks++; if (IF_kick_up !== 1'b0) begin failures++; $display("FAIL seq_kick_width got %b exp 0", IF_kick_up); end
    end
  endtask

  task automatic test_branch_jal;
    logic st;
    commit(2'b00, 1'b0, 32'h0, 32'h0);         // 0xC -> 0x10
    serve_fetch(0, 0, 32'h0000_0063, st); @(negedge clk);
    commit(2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0); // not taken
    checks++; if (bus.imem_addr !== 32'h14) begin failures++; $display("FAIL br_nt got %h exp 14", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0013, st); @(negedge clk);
    commit(2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0); // JAL back to 0x10
    checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL jal_back got %h exp 10", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0063, st); @(negedge clk);
    commit(2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0); // taken
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL br_t got %h exp 0", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0013, st); @(negedge clk);
    commit(2'b10, 1'b0, 32'h10, 32'h0);        // JAL 0x0 -> 0x10
    serve_fetch(0, 0, 32'h1000_006F, st); @(negedge clk);
    checks++; if (pc_plus4 !== 32'h14) begin failures++; $display("FAIL jal_link got %h exp 14", pc_plus4); end
    commit(2'b10, 1'b0, 32'h100, 32'h0);
    checks++; if (bus.imem_addr !== 32'h110) begin failures++; $display("FAIL jal_target got %h exp 110", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0013, st); @(negedge clk);
  endtask

  task automatic test_jalr;
    logic st;
    commit(2'b11, 1'b0, 32'h1, 32'h203);
    checks++; if (bus.imem_addr !== 32'h204) begin failures++; $display("FAIL jalr_bit0 got %h exp 204", bus.imem_addr); end
    // commit and response outside their states must be ignored
    WB_kick_up = 1'b1; redirect_type = 2'b10; imme = 32'h40;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    WB_kick_up = 1'b0; redirect_type = 2'b00; imme = 32'h0; bus.imem_rvalid = 1'b0;
    checks++; if (bus.imem_addr !== 32'h204 || bus.imem_req !== 1'b1 || IF_kick_up !== 1'b0) begin
      failures++; $display("FAIL ignore_in_fetch got %h/%b/%b exp 204/1/0", bus.imem_addr, bus.imem_req, IF_kick_up); end
    serve_fetch(0, 0, 32'h0000_8067, st);
    checks++; if (inst_pc !== 32'h204 || inst !== 32'h0000_8067) begin failures++; $display("FAIL jalr_fetch got %h/%h exp 204/00008067", inst_pc, inst); end
    @(negedge clk);
    commit(2'b11, 1'b0, 32'h0, 32'h201);
    checks++; if (bus.imem_addr !== 32'h200) begin failures++; $display("FAIL jalr_201 got %h exp 200", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0067, st); @(negedge clk);
  endtask

  task automatic test_fault;
    commit(2'b11, 1'b0, 32'h0, 32'h102);
    checks++; if (misalign_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h200) begin
      failures++; $display("FAIL fault_enter got %b/%b/%h exp 1/0/200", misalign_fault, bus.imem_req, bus.imem_addr); end
    WB_kick_up = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; bus.imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0 || IF_kick_up !== 1'b0 || misalign_fault !== 1'b1 || bus.imem_addr !== 32'h200 || inst !== 32'h0000_0067) begin
        failures++; $display("FAIL fault_sticky got %b/%b/%b/%h/%h exp 0/0/1/200/00000067", bus.imem_req, IF_kick_up, misalign_fault, bus.imem_addr, inst); end
    end
    WB_kick_up = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (misalign_fault !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
      failures++; $display("FAIL fault_clear got %b/%h/%b exp 0/0/1", misalign_fault, bus.imem_addr, bus.imem_req); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5673;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    checks++; if (IF_kick_up !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1 || inst !== 32'h0000_0013) begin
      failures++; $display("FAIL rst_wait got %b/%h/%b/%h exp 0/0/1/00000013", IF_kick_up, bus.imem_addr, bus.imem_req, inst); end
    @(negedge clk);
    checks++; if (IF_kick_up !== 1'b0) begin failures++; $display("FAIL rst_wait_kick got %b exp 0", IF_kick_up); end
  endtask

  task automatic test_same_cycle_and_wrap;
    logic st;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_0013;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (IF_kick_up !== 1'b0 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL same_cycle_rsp got %b/%b exp 0/0", IF_kick_up, bus.imem_req); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0067;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    checks++; if (IF_kick_up !== 1'b1 || inst !== 32'h0000_0067) begin failures++; $display("FAIL late_rsp got %b/%h exp 1/00000067", IF_kick_up, inst); end
    @(negedge clk);
    commit(2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jalr got %h exp fffffffc", bus.imem_addr); end
    serve_fetch(0, 0, 32'h0000_0013, st);
    checks++; if (pc_plus4 !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_link got %h/%h exp 0/fffffffc", pc_plus4, inst_pc); end
    @(negedge clk);
    commit(2'b00, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL wrap_seq got %h/%b exp 0/1", bus.imem_addr, bus.imem_req); end
  endtask

  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch_jal();
    test_jalr();
    test_fault();
    test_reset_in_wait();
    test_same_cycle_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
